// File: rtl/fq_ts_arbiter.sv
// Round-robin arbiter sharing one FQ timestamp-generator among NREQ requesters,
// with bounded burst grants, a global stall and a one-cycle registered response.
`ifndef TS_WIDTH
`define TS_WIDTH 16
`endif

module fq_ts_arbiter #(
  parameter int NREQ     = 4,
  parameter int TS_WIDTH = `TS_WIDTH,
  parameter int BURST    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*TS_WIDTH-1:0] req_ts,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fq_in_ready,
  output logic [TS_WIDTH-1:0]      fq_in_timestamp,
  input  logic [TS_WIDTH-1:0]      fq_out_timestamp,
  output logic [NREQ-1:0]          resp_valid,
  output logic [TS_WIDTH-1:0]      resp_ts
);

  localparam int         IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] BURST_C = 4'(BURST);

  logic [IW-1:0]       ptr_r, last_r;
  logic [3:0]          bcnt_r;
  logic [NREQ-1:0]     resp_valid_r;
  logic [TS_WIDTH-1:0] resp_ts_r;

  logic [IW-1:0]       cand_s, win_idx_s, ptr_nxt_s, last_nxt_s;
  logic                win_found_s, grant_s;
  logic [NREQ-1:0]     grant_oh_s;
  logic [3:0]          bcnt_inc_s, bcnt_nxt_s;
  logic [TS_WIDTH-1:0] fq_ts_s;

  // Circular search for the first valid requester starting at the pointer
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((32'(ptr_r) + 32'(k)) % 32'(NREQ));
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant decode; reset and stall both suppress the winner
  always_comb begin
    grant_s = win_found_s & ~stall & ~reset;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh_s[i] = grant_s && (win_idx_s == IW'(i));
    end
    if (grant_s) begin
      fq_ts_s = req_ts[32'(win_idx_s)*TS_WIDTH +: TS_WIDTH];
    end else begin
      fq_ts_s = {TS_WIDTH{1'b0}};
    end
  end

  // Pointer / burst bookkeeping: a winner keeps priority until its burst is used up
  always_comb begin
    ptr_nxt_s  = ptr_r;
    last_nxt_s = last_r;
    bcnt_nxt_s = bcnt_r;
    bcnt_inc_s = 4'd1;
    if (grant_s) begin
      last_nxt_s = win_idx_s;
      if ((win_idx_s == last_r) && (bcnt_r != 4'd0)) begin
        bcnt_inc_s = bcnt_r + 4'd1;
      end else begin
        bcnt_inc_s = 4'd1;
      end
      if (bcnt_inc_s == BURST_C) begin
        ptr_nxt_s  = (win_idx_s == IW'(NREQ-1)) ? {IW{1'b0}} : win_idx_s + IW'(1);
        bcnt_nxt_s = 4'd0;
      end else begin
        ptr_nxt_s  = win_idx_s;
        bcnt_nxt_s = bcnt_inc_s;
      end
    end else if (!stall && (req_valid == {NREQ{1'b0}})) begin
      // Only a truly idle cycle ends a burst; a stall preserves it
      bcnt_nxt_s = 4'd0;
    end else begin
      bcnt_nxt_s = bcnt_r;
    end
  end

  // State and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r        <= {IW{1'b0}};
      last_r       <= {IW{1'b0}};
      bcnt_r       <= 4'd0;
      resp_valid_r <= {NREQ{1'b0}};
      resp_ts_r    <= {TS_WIDTH{1'b0}};
    end else begin
      ptr_r        <= ptr_nxt_s;
      last_r       <= last_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      resp_valid_r <= grant_oh_s;
      if (grant_s) begin
        resp_ts_r <= fq_out_timestamp;
      end else begin
        resp_ts_r <= resp_ts_r;
      end
    end
  end

  assign req_ready       = grant_oh_s;
  assign fq_in_ready     = grant_s;
  assign fq_in_timestamp = fq_ts_s;
  assign resp_valid      = resp_valid_r;
  assign resp_ts         = resp_ts_r;

endmodule

// File: tb/tb_fq_ts_arbiter.sv
// Directed bench for fq_ts_arbiter: one instance with BURST=1, one with BURST=3,
// each with an echoing control unit (out_timestamp = in_timestamp).
module tb_fq_ts_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] req_ts;

  logic        stall1, stall3;
  logic [3:0]  rv1, rv3, rr1, rr3, rsp1, rsp3;
  logic        fir1, fir3;
  logic [15:0] fit1, fit3, fot1, fot3, rts1, rts3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign fot1 = fit1;
  assign fot3 = fit3;

  fq_ts_arbiter #(.NREQ(4), .TS_WIDTH(16), .BURST(1)) u1 (
    .clock(clock), .reset(reset), .stall(stall1), .req_valid(rv1), .req_ts(req_ts),
    .req_ready(rr1), .fq_in_ready(fir1), .fq_in_timestamp(fit1),
    .fq_out_timestamp(fot1), .resp_valid(rsp1), .resp_ts(rts1)
  );

  fq_ts_arbiter #(.NREQ(4), .TS_WIDTH(16), .BURST(3)) u3 (
    .clock(clock), .reset(reset), .stall(stall3), .req_valid(rv3), .req_ts(req_ts),
    .req_ready(rr3), .fq_in_ready(fir3), .fq_in_timestamp(fit3),
    .fq_out_timestamp(fot3), .resp_valid(rsp3), .resp_ts(rts3)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rv1 = 4'b1111; rv3 = 4'b1111;
    @(negedge clock);
    total++; if (rr1 !== 4'b0000) begin bad++; $display("FAIL reset_rr1 got=%b exp=0000", rr1); end
    total++; if (fir1 !== 1'b0) begin bad++; $display("FAIL reset_fir1 got=%b exp=0", fir1); end
    total++; if (rr3 !== 4'b0000) begin bad++; $display("FAIL reset_rr3 got=%b exp=0000", rr3); end
    @(posedge clock); #1;
    total++; if (rsp1 !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0000", rsp1); end
    total++; if (rts1 !== 16'd0) begin bad++; $display("FAIL reset_resp_ts got=%0d exp=0", rts1); end
    reset = 1'b0; rv1 = 4'b0000; rv3 = 4'b0000;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  exp_oh;
    logic [15:0] exp_ts;
    rv1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << order[k];
      exp_ts = 16'(10 * (order[k] + 1));
      @(negedge clock);
      total++; if (rr1 !== exp_oh) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, rr1, exp_oh); end
      total++; if (fit1 !== exp_ts) begin bad++; $display("FAIL rr_in_ts[%0d] got=%0d exp=%0d", k, fit1, exp_ts); end
      @(posedge clock); #1;
      total++; if (rsp1 !== exp_oh) begin bad++; $display("FAIL rr_resp_valid[%0d] got=%b exp=%b", k, rsp1, exp_oh); end
      total++; if (rts1 !== exp_ts) begin bad++; $display("FAIL rr_resp_ts[%0d] got=%0d exp=%0d", k, rts1, exp_ts); end
    end
    rv1 = 4'b0000;
  endtask

  task automatic test_burst();
    // Step 6 adds requester 3: with the pointer at 3 after the burst to 2, it wins.
    logic [3:0] rvs [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1110, 4'b0110};
    int order [8] = '{1, 1, 1, 2, 2, 2, 3, 1};
    logic [3:0]  exp_oh;
    logic [15:0] exp_ts;
    for (int k = 0; k < 8; k++) begin
      rv3 = rvs[k];
      exp_oh = 4'b0001 << order[k];
      exp_ts = 16'(10 * (order[k] + 1));
      @(negedge clock);
      total++; if (rr3 !== exp_oh) begin bad++; $display("FAIL burst_grant[%0d] got=%b exp=%b", k, rr3, exp_oh); end
      @(posedge clock); #1;
      total++; if (rsp3 !== exp_oh) begin bad++; $display("FAIL burst_resp_valid[%0d] got=%b exp=%b", k, rsp3, exp_oh); end
      total++; if (rts3 !== exp_ts) begin bad++; $display("FAIL burst_resp_ts[%0d] got=%0d exp=%0d", k, rts3, exp_ts); end
    end
    rv3 = 4'b0000;
    @(posedge clock); #1;
  endtask

  task automatic test_stall();
    int order [4] = '{0, 0, 0, 1};
    logic [3:0] exp_oh;
    do_reset();
    rv3 = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if (rr3 !== 4'b0001) begin bad++; $display("FAIL stall_pre_grant[%0d] got=%b exp=0001", k, rr3); end
      @(posedge clock); #1;
    end
    stall3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if (fir3 !== 1'b0) begin bad++; $display("FAIL stall_fq_in_ready[%0d] got=%b exp=0", k, fir3); end
      total++; if (rr3 !== 4'b0000) begin bad++; $display("FAIL stall_rr[%0d] got=%b exp=0000", k, rr3); end
      @(posedge clock); #1;
      total++; if (rsp3 !== 4'b0000) begin bad++; $display("FAIL stall_resp_valid[%0d] got=%b exp=0000", k, rsp3); end
    end
    stall3 = 1'b0;
    for (int k = 2; k < 4; k++) begin
      exp_oh = 4'b0001 << order[k];
      @(negedge clock);
      total++; if (rr3 !== exp_oh) begin bad++; $display("FAIL stall_post_grant[%0d] got=%b exp=%b", k, rr3, exp_oh); end
      @(posedge clock); #1;
      total++; if (rsp3 !== exp_oh) begin bad++; $display("FAIL stall_post_resp[%0d] got=%b exp=%b", k, rsp3, exp_oh); end
    end
    rv3 = 4'b0000;
  endtask

  task automatic test_single();
    rv1 = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      total++; if (rr1 !== 4'b1000) begin bad++; $display("FAIL single_grant[%0d] got=%b exp=1000", k, rr1); end
      @(posedge clock); #1;
      total++; if (rsp1 !== 4'b1000) begin bad++; $display("FAIL single_resp_valid[%0d] got=%b exp=1000", k, rsp1); end
      total++; if (rts1 !== 16'd40) begin bad++; $display("FAIL single_resp_ts[%0d] got=%0d exp=40", k, rts1); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; rv1 = 4'b0100;
    @(negedge clock);
    total++; if (rr1 !== 4'b0000) begin bad++; $display("FAIL midreset_rr got=%b exp=0000", rr1); end
    total++; if (fir1 !== 1'b0) begin bad++; $display("FAIL midreset_fq_in_ready got=%b exp=0", fir1); end
    @(posedge clock); #1;
    total++; if (rsp1 !== 4'b0000) begin bad++; $display("FAIL midreset_resp_valid got=%b exp=0000", rsp1); end
    total++; if (rts1 !== 16'd0) begin bad++; $display("FAIL midreset_resp_ts got=%0d exp=0", rts1); end
    reset = 1'b0; rv1 = 4'b0111;
    @(negedge clock);
    total++; if (rr1 !== 4'b0001) begin bad++; $display("FAIL midreset_ptr_zero got=%b exp=0001", rr1); end
    @(posedge clock); #1;
    rv1 = 4'b0000;
  endtask

  task automatic test_withdraw();
    do_reset();
    rv1 = 4'b0011;
    #1;
    rv1 = 4'b0010;
    @(negedge clock);
    total++; if (rr1 !== 4'b0010) begin bad++; $display("FAIL withdraw_grant got=%b exp=0010", rr1); end
    @(posedge clock); #1;
    total++; if (rsp1 !== 4'b0010) begin bad++; $display("FAIL withdraw_resp_valid got=%b exp=0010", rsp1); end
    total++; if (rts1 !== 16'd20) begin bad++; $display("FAIL withdraw_resp_ts got=%0d exp=20", rts1); end
    rv1 = 4'b0000;
    @(negedge clock);
    total++; if (rr1 !== 4'b0000) begin bad++; $display("FAIL withdraw_idle_grant got=%b exp=0000", rr1); end
    @(posedge clock); #1;
    total++; if (rsp1 !== 4'b0000) begin bad++; $display("FAIL withdraw_idle_resp got=%b exp=0000", rsp1); end
  endtask

  initial begin
    reset  = 1'b1;
    stall1 = 1'b0; stall3 = 1'b0;
    rv1    = 4'b0000; rv3 = 4'b0000;
    req_ts = {16'd40, 16'd30, 16'd20, 16'd10};
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_single();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
